mac_learning_table: RTL

Parametrised MAC address learning/forwarding table for the switch core. It learns source MACs per ingress port and resolves destination lookups to an egress port or a flood decision with fixed 1-cycle latency. It adds hardware aging, station-move detection, oldest-entry eviction and per-port/global flush. It sits between the ingress parser (learn/lookup requests) and the forwarding arbiter (lookup results).

---
 rtl/mac_learning_table.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mac_learning_table.sv
// MAC learning/forwarding table: learns source MACs per port and resolves destination lookups.
// Includes hardware aging, station-move detection, oldest-entry eviction and port/global flush.
module mac_learning_table #(
  parameter int NUM_PORTS       = 4,
  parameter int NUM_ENTRIES     = 16,
  parameter int AGE_WIDTH       = 4,
  parameter int AGE_LIMIT       = 15,
  parameter int AGE_TICK_CYCLES = 1024,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int IW = $clog2(NUM_ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          learn_req_i,
  input  logic [47:0]   learn_addr_i,
  input  logic [PW-1:0] learn_port_i,
  input  logic          lookup_req_i,
  input  logic [47:0]   lookup_addr_i,
  input  logic          flush_req_i,
  input  logic          flush_all_i,
  input  logic [PW-1:0] flush_port_i,
  output logic          lookup_valid_o,
  output logic          lookup_hit_o,
  output logic [PW-1:0] lookup_port_o,
  output logic          lookup_flood_o,
  output logic          station_move_o,
  output logic          evict_o,
  output logic          learn_drop_o,
  output logic [IW:0]   entry_count_o
);

  localparam int TW = $clog2(AGE_TICK_CYCLES);
  localparam int CW = IW + 1;

  logic [TW-1:0]        presc;
  logic                 tick;
  logic [NUM_ENTRIES-1:0] valid, valid_nxt;
  logic [47:0]          mac  [NUM_ENTRIES];
  logic [PW-1:0]        port [NUM_ENTRIES];
  logic [AGE_WIDTH-1:0] age  [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] learn_match, lookup_match, flush_match;
  logic                 learn_hit, lookup_hit, table_full;
  logic [IW-1:0]        learn_idx, lookup_idx, free_idx, oldest_idx, wr_idx;
  logic [AGE_WIDTH-1:0] oldest_age;
  logic                 learn_ok, move, evict, drop;
  logic [CW-1:0]        count_nxt;

  assign tick = (presc == TW'(AGE_TICK_CYCLES - 1));

  always_comb begin
    learn_match  = '0;
    lookup_match = '0;
    flush_match  = '0;
    learn_idx    = '0;
    lookup_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      learn_match[i]  = valid[i] && (mac[i] == learn_addr_i);
      lookup_match[i] = valid[i] && (mac[i] == lookup_addr_i);
      flush_match[i]  = flush_req_i && (flush_all_i || (valid[i] && (port[i] == flush_port_i)));
      if (learn_match[i])  learn_idx  = IW'(i);
      if (lookup_match[i]) lookup_idx = IW'(i);
    end
    learn_hit  = |learn_match;
    lookup_hit = |lookup_match;
    table_full = &valid;

    // descending scan so the lowest free index wins
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = IW'(i);
    end

    // strict compare keeps the lowest index on equal ages
    oldest_idx = '0;
    oldest_age = age[0];
    for (int i = 1; i < NUM_ENTRIES; i++) begin
      if (age[i] > oldest_age) begin
        oldest_age = age[i];
        oldest_idx = IW'(i);
      end
    end

    learn_ok = learn_req_i && !flush_req_i && !learn_addr_i[40];
    drop     = learn_req_i && (flush_req_i || learn_addr_i[40]);
    move     = learn_ok && learn_hit && (port[learn_idx] != learn_port_i);
    evict    = learn_ok && !learn_hit && table_full;
    wr_idx   = learn_hit ? learn_idx : (table_full ? oldest_idx : free_idx);

    valid_nxt = valid;
    count_nxt = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (flush_match[i])
        valid_nxt[i] = 1'b0;
      else if (learn_ok && (wr_idx == IW'(i)))
        valid_nxt[i] = 1'b1;
      else if (tick && valid[i] && (age[i] == AGE_WIDTH'(AGE_LIMIT)))
        valid_nxt[i] = 1'b0;
      count_nxt = count_nxt + CW'(valid_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc          <= '0;
      valid          <= '0;
      entry_count_o  <= '0;
      station_move_o <= 1'b0;
      evict_o        <= 1'b0;
      learn_drop_o   <= 1'b0;
      lookup_valid_o <= 1'b0;
      lookup_hit_o   <= 1'b0;
      lookup_flood_o <= 1'b0;
      lookup_port_o  <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        mac[i]  <= '0;
        port[i] <= '0;
        age[i]  <= '0;
      end
    end else begin
      presc          <= tick ? '0 : presc + TW'(1);
      valid          <= valid_nxt;
      entry_count_o  <= count_nxt;
      station_move_o <= move;
      evict_o        <= evict;
      learn_drop_o   <= drop;

      // lookup sees the table as it was before this cycle's updates
      lookup_valid_o <= lookup_req_i;
      lookup_hit_o   <= lookup_req_i && !lookup_addr_i[40] && lookup_hit;
      lookup_flood_o <= lookup_req_i && (lookup_addr_i[40] || !lookup_hit);
      lookup_port_o  <= (lookup_req_i && !lookup_addr_i[40] && lookup_hit) ? port[lookup_idx] : '0;

      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (learn_ok && (wr_idx == IW'(i))) begin
          mac[i]  <= learn_addr_i;
          port[i] <= learn_port_i;
          age[i]  <= '0;
        end else if (tick && valid[i] && (age[i] != AGE_WIDTH'(AGE_LIMIT))) begin
          age[i] <= age[i] + AGE_WIDTH'(1);
        end
      end
    end
  end

endmodule
